// File: rtl/ftq_read_arbiter.sv
// FTQ read-port arbiter: shares PORT_NUM FTQ read ports between the ROB (fixed priority)
// and the BRUs (round-robin with starvation escape), returning addresses one cycle later.
module ftq_read_arbiter #(
    parameter int unsigned REQ_NUM    = 3,
    parameter int unsigned PORT_NUM   = 2,
    parameter int unsigned FTQIDX_W   = 4,
    parameter int unsigned XLEN       = 64,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_squash_vld,
    input  logic [REQ_NUM-1:0]                 i_req_vld,
    input  logic [REQ_NUM-1:0][FTQIDX_W-1:0]   i_req_ftqIdx,
    output logic [REQ_NUM-1:0]                 o_req_gnt,
    output logic [REQ_NUM-1:0]                 o_rsp_vld,
    output logic [REQ_NUM-1:0][XLEN-1:0]       o_rsp_startAddr,
    output logic [REQ_NUM-1:0][XLEN-1:0]       o_rsp_nextAddr,
    output logic [PORT_NUM-1:0][FTQIDX_W-1:0]  o_read_ftqIdx,
    output logic [PORT_NUM-1:0]                o_read_vld,
    input  logic [PORT_NUM-1:0][XLEN-1:0]      i_read_ftqStartAddr,
    input  logic [PORT_NUM-1:0][XLEN-1:0]      i_read_ftqNextAddr
);
    localparam int unsigned PTR_W  = $clog2(REQ_NUM);
    localparam int unsigned CNT_W  = $clog2(STARVE_LIM + 1);
    localparam int unsigned PSEL_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [PTR_W-1:0]                r_rr_ptr;
    logic [REQ_NUM-1:0][CNT_W-1:0]   r_starve;
    logic [REQ_NUM-1:0]              r_rsp_vld;
    logic [REQ_NUM-1:0][XLEN-1:0]    r_rsp_start;
    logic [REQ_NUM-1:0][XLEN-1:0]    r_rsp_next;

    logic [REQ_NUM-1:0]              w_gnt;
    logic [REQ_NUM-1:0][PSEL_W-1:0]  w_gnt_port;
    logic                            w_rr_any;
    logic [PTR_W-1:0]                w_rr_last;
    logic [REQ_NUM-1:0][XLEN-1:0]    w_sel_start;
    logic [REQ_NUM-1:0][XLEN-1:0]    w_sel_next;

    // Grant pass: starved BRUs, then ROB, then BRUs in round-robin order from the pointer.
    always_comb begin
        int unsigned n;
        n          = 0;
        w_gnt      = '0;
        w_gnt_port = '0;
        w_rr_any   = 1'b0;
        w_rr_last  = '0;
        if (!rst) begin
            for (int i = 1; i < REQ_NUM; i++) begin
                if (i_req_vld[i] && r_starve[i] == CNT_W'(STARVE_LIM) && n < PORT_NUM) begin
                    w_gnt[i]      = 1'b1;
                    w_gnt_port[i] = PSEL_W'(n);
                    n++;
                end
            end
            if (i_req_vld[0] && n < PORT_NUM) begin
                w_gnt[0]      = 1'b1;
                w_gnt_port[0] = PSEL_W'(n);
                n++;
            end
            // Pass 0 covers pointer..REQ_NUM-1, pass 1 wraps to 1..pointer-1.
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 1; i < REQ_NUM; i++) begin
                    if (((pass == 0) == (PTR_W'(i) >= r_rr_ptr)) && i_req_vld[i] && !w_gnt[i]
                        && n < PORT_NUM) begin
                        w_gnt[i]      = 1'b1;
                        w_gnt_port[i] = PSEL_W'(n);
                        w_rr_any      = 1'b1;
                        w_rr_last     = PTR_W'(i);
                        n++;
                    end
                end
            end
        end
    end

    always_comb begin
        o_read_ftqIdx = '0;
        o_read_vld    = '0;
        w_sel_start   = '0;
        w_sel_next    = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (w_gnt[i] && w_gnt_port[i] == PSEL_W'(p)) begin
                    o_read_vld[p]    = 1'b1;
                    o_read_ftqIdx[p] = i_req_ftqIdx[i];
                    w_sel_start[i]   = i_read_ftqStartAddr[p];
                    w_sel_next[i]    = i_read_ftqNextAddr[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= PTR_W'(1);
            r_starve    <= '0;
            r_rsp_vld   <= '0;
            r_rsp_start <= '0;
            r_rsp_next  <= '0;
        end else begin
            for (int k = 0; k < REQ_NUM; k++) begin
                r_rsp_vld[k] <= w_gnt[k] && ((k == 0) || !i_squash_vld);
                if (w_gnt[k]) begin
                    r_rsp_start[k] <= w_sel_start[k];
                    r_rsp_next[k]  <= w_sel_next[k];
                end
            end
            for (int k = 1; k < REQ_NUM; k++) begin
                if (i_squash_vld || !i_req_vld[k] || w_gnt[k]) begin
                    r_starve[k] <= '0;
                end else if (r_starve[k] != CNT_W'(STARVE_LIM)) begin
                    r_starve[k] <= r_starve[k] + 1'b1;
                end
            end
            if (w_rr_any) begin
                r_rr_ptr <= (w_rr_last == PTR_W'(REQ_NUM - 1)) ? PTR_W'(1) : w_rr_last + 1'b1;
            end
        end
    end

    // A squash in the response cycle still kills BRU responses; the ROB is never squashed.
    assign o_rsp_vld       = r_rsp_vld & ~{{(REQ_NUM-1){i_squash_vld}}, 1'b0};
    assign o_req_gnt       = w_gnt;
    assign o_rsp_startAddr = r_rsp_start;
    assign o_rsp_nextAddr  = r_rsp_next;

    a_gnt_count: assert property (@(posedge clk) disable iff (rst)
        $countones(w_gnt) <= PORT_NUM);
    a_gnt_valid: assert property (@(posedge clk) disable iff (rst)
        (w_gnt & ~i_req_vld) == '0);
    a_one_port: assert property (@(posedge clk) disable iff (rst)
        $countones(o_read_vld) == $countones(w_gnt));
endmodule

// File: tb/tb_ftq_read_arbiter.sv
// Scoreboard bench for ftq_read_arbiter: directed vectors on a 2-port instance,
// plus starvation/squash-clear checks on a 1-port instance.
module tb_ftq_read_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (PORT_NUM = 2)
    logic             rst = 1'b1;
    logic             squash = 1'b0;
    logic [2:0]       req_vld = '0;
    logic [2:0][3:0]  req_idx = '0;
    logic [2:0]       gnt;
    logic [2:0]       rsp_vld;
    logic [2:0][63:0] rsp_start, rsp_next;
    logic [1:0][3:0]  rd_idx;
    logic [1:0]       rd_vld;
    logic [1:0][63:0] ftq_start, ftq_next;

    // Single-port instance
    logic             rst1 = 1'b1;
    logic             sq1 = 1'b0;
    logic [2:0]       vld1 = '0;
    logic [2:0][3:0]  idx1 = {4'd3, 4'd2, 4'd1};
    logic [2:0]       gnt1;
    logic [2:0]       rsp_vld1;
    logic [2:0][63:0] rsp_start1, rsp_next1;
    logic [0:0][3:0]  rd_idx1;
    logic [0:0]       rd_vld1;
    logic [0:0][63:0] ftq_start1, ftq_next1;

    ftq_read_arbiter u_dut (
        .clk(clk), .rst(rst), .i_squash_vld(squash), .i_req_vld(req_vld),
        .i_req_ftqIdx(req_idx), .o_req_gnt(gnt), .o_rsp_vld(rsp_vld),
        .o_rsp_startAddr(rsp_start), .o_rsp_nextAddr(rsp_next), .o_read_ftqIdx(rd_idx),
        .o_read_vld(rd_vld), .i_read_ftqStartAddr(ftq_start), .i_read_ftqNextAddr(ftq_next)
    );

    ftq_read_arbiter #(.PORT_NUM(1)) u_dut1 (
        .clk(clk), .rst(rst1), .i_squash_vld(sq1), .i_req_vld(vld1),
        .i_req_ftqIdx(idx1), .o_req_gnt(gnt1), .o_rsp_vld(rsp_vld1),
        .o_rsp_startAddr(rsp_start1), .o_rsp_nextAddr(rsp_next1), .o_read_ftqIdx(rd_idx1),
        .o_read_vld(rd_vld1), .i_read_ftqStartAddr(ftq_start1), .i_read_ftqNextAddr(ftq_next1)
    );

    // FTQ contents: idx 3 -> 0x1000, idx 5 -> 0x2000; nextAddress sits 0x40 above.
    function automatic logic [63:0] f_start(input logic [3:0] idx);
        return 64'(idx) * 64'h800 - 64'h800;
    endfunction
    function automatic logic [63:0] f_next(input logic [3:0] idx);
        return f_start(idx) + 64'h40;
    endfunction

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ftq_start[p] = f_start(rd_idx[p]);
            ftq_next[p]  = f_next(rd_idx[p]);
        end
        ftq_start1[0] = f_start(rd_idx1[0]);
        ftq_next1[0]  = f_next(rd_idx1[0]);
    end

    typedef struct {
        logic       r;
        logic       sq;
        logic [2:0] vld;
        logic [3:0] i0, i1, i2;
        logic [2:0] gnt;
        logic [1:0] pv;
        logic [3:0] p0, p1;
    } vec_t;

    typedef struct {
        int          k;
        logic [63:0] s;
        logic [63:0] n;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic sq, input logic [2:0] vld,
                                input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2,
                                input logic [2:0] g, input logic [1:0] pv,
                                input logic [3:0] p0, input logic [3:0] p1);
        vec_t v;
        v.r = r; v.sq = sq; v.vld = vld; v.i0 = i0; v.i1 = i1; v.i2 = i2;
        v.gnt = g; v.pv = pv; v.p0 = p0; v.p1 = p1;
        vecs.push_back(v);
    endfunction

    function automatic logic [3:0] idx_of(input vec_t v, input int k);
        return (k == 0) ? v.i0 : (k == 1) ? v.i1 : v.i2;
    endfunction

    // Monitor: every presented response pops the oldest expected one.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 3; k++) begin
                if (rsp_vld[k] === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got rsp_vld[%0d]=1, expected 0 (t=%0t)",
                                 k, $time);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_req", 64'(k), 64'(e.k));
                        check("rsp_start", rsp_start[k], e.s);
                        check("rsp_next", rsp_next[k], e.n);
                    end
                end
            end
        end
    end

    task automatic run1(input logic r, input logic sq, input logic [2:0] exp, input string name);
        @(negedge clk);
        rst1 = r;
        sq1  = sq;
        vld1 = 3'b111;
        #1 check(name, 64'(gnt1), 64'(exp));
    endtask

    initial begin
        vec_t v, prev;
        rsp_t e;
        logic [2:0] seq1 [7];
        seq1 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b001};

        add(1, 0, 3'b111, 1, 2, 4, 3'b000, 2'b00, 0, 0);
        add(1, 0, 3'b111, 1, 2, 4, 3'b000, 2'b00, 0, 0);
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0) add(0, 0, 3'b111, 1, 2, 4, 3'b011, 2'b11, 1, 2);
            else            add(0, 0, 3'b111, 1, 2, 4, 3'b101, 2'b11, 1, 4);
        end
        add(0, 0, 3'b011, 3, 5, 0,   3'b011, 2'b11, 3, 5);
        add(0, 0, 3'b000, 0, 0, 0,   3'b000, 2'b00, 0, 0);
        add(0, 1, 3'b101, 6, 0, 7,   3'b101, 2'b11, 6, 7);
        add(0, 0, 3'b010, 0, 9, 0,   3'b010, 2'b01, 9, 0);
        add(0, 1, 3'b001, 2, 0, 0,   3'b001, 2'b01, 2, 0);
        add(0, 1, 3'b110, 0, 8, 8,   3'b110, 2'b11, 8, 8);
        add(0, 0, 3'b110, 0, 10, 11, 3'b110, 2'b11, 11, 10);
        add(1, 0, 3'b111, 12, 13, 14, 3'b000, 2'b00, 0, 0);
        add(0, 0, 3'b111, 12, 13, 14, 3'b011, 2'b11, 12, 13);
        add(0, 0, 3'b000, 0, 0, 0,   3'b000, 2'b00, 0, 0);
        add(0, 0, 3'b000, 0, 0, 0,   3'b000, 2'b00, 0, 0);

        prev = vecs[0];
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            rst = v.r;
            squash = v.sq;
            req_vld = v.vld;
            req_idx = {v.i2, v.i1, v.i0};
            if (i > 0) begin
                for (int k = 0; k < 3; k++) begin
                    if (prev.gnt[k] && !(k != 0 && (prev.sq || v.sq))) begin
                        e.k = k;
                        e.s = f_start(idx_of(prev, k));
                        e.n = f_next(idx_of(prev, k));
                        sb.push_back(e);
                    end
                end
            end
            #1;
            check("gnt", 64'(gnt), 64'(v.gnt));
            check("read_vld", 64'(rd_vld), 64'(v.pv));
            check("read_idx0", 64'(rd_idx[0]), 64'(v.p0));
            check("read_idx1", 64'(rd_idx[1]), 64'(v.p1));
            if (i == 2) begin
                check("rsp_start_reset", rsp_start, 192'(0));
                check("rsp_next_reset", rsp_next, 192'(0));
            end
            prev = v;
        end

        run1(1, 0, 3'b000, "p1_rst");
        for (int j = 0; j < 7; j++) run1(0, 0, seq1[j], "p1_starve");
        run1(1, 0, 3'b000, "p1_rst2");
        for (int j = 0; j < 3; j++) run1(0, 0, 3'b001, "p1_pre_squash");
        run1(0, 1, 3'b001, "p1_squash_rob");
        for (int j = 0; j < 4; j++) run1(0, 0, 3'b001, "p1_post_squash");
        run1(0, 0, 3'b010, "p1_starve_again");

        @(negedge clk);
        #3;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
